// File: rtl/lfsr_enc_pkg.sv
// rtl/lfsr_enc_pkg.sv - shared states and constants for the lfsr encryption sequencer
package lfsr_enc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_PRE   = 3'd1,
        RD_TAPS  = 3'd2,
        RD_START = 3'd3,
        LOAD     = 3'd4,
        PRE      = 3'd5,
        MSG      = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [7:0] PRE_ADDR   = 8'd61;
    localparam logic [7:0] TAPS_ADDR  = 8'd62;
    localparam logic [7:0] START_ADDR = 8'd63;
    localparam logic [7:0] PAD_CHAR   = 8'h5F;

endpackage

// File: rtl/lfsr_enc_seq.sv
// rtl/lfsr_enc_seq.sv - sequencer: load lfsr6 from config bytes, write padded preamble and encrypted message
module lfsr_enc_seq
    import lfsr_enc_pkg::*;
#(
    parameter int unsigned MSG_LEN  = 50,
    parameter int unsigned MAX_PRE  = 14,
    parameter int unsigned OUT_BASE = 64
) (
    input  logic       clk,
    input  logic       init,
    input  logic       go,
    output logic [7:0] raddr,
    output logic [7:0] waddr,
    output logic       write_en,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       LFSR_en,
    output logic       load_LFSR,
    output logic [5:0] taps,
    output logic [5:0] start,
    input  logic [5:0] LFSR,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] BASE8    = 8'(OUT_BASE);
    localparam logic [7:0] MAXPRE8  = 8'(MAX_PRE);
    localparam logic [7:0] LAST_MSG = 8'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] pre_len_q, pre_len_d;
    logic [5:0] taps_q, taps_d;
    logic [5:0] start_q, start_d;
    logic [7:0] k_q, k_d;
    logic [7:0] j_q, j_d;

    assign taps  = taps_q;
    assign start = start_q;

    always_comb begin
        state_d   = state_q;
        pre_len_d = pre_len_q;
        taps_d    = taps_q;
        start_d   = start_q;
        k_d       = k_q;
        j_d       = j_q;
        raddr     = 8'd0;
        waddr     = BASE8;
        write_en  = 1'b0;
        data_in   = 8'd0;
        LFSR_en   = 1'b0;
        load_LFSR = 1'b0;
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (go) state_d = RD_PRE;
            end
            RD_PRE: begin
                raddr     = PRE_ADDR;
                pre_len_d = (data_out > MAXPRE8) ? MAXPRE8 : data_out;
                state_d   = RD_TAPS;
            end
            RD_TAPS: begin
                raddr   = TAPS_ADDR;
                taps_d  = data_out[5:0];
                state_d = RD_START;
            end
            RD_START: begin
                raddr   = START_ADDR;
                start_d = data_out[5:0];
                state_d = LOAD;
            end
            LOAD: begin
                load_LFSR = 1'b1;
                k_d       = 8'd0;
                j_d       = 8'd0;
                state_d   = (pre_len_q != 8'd0) ? PRE : MSG;
            end
            PRE: begin
                write_en = 1'b1;
                waddr    = BASE8 + k_q;
                data_in  = PAD_CHAR ^ {2'b00, LFSR};
                LFSR_en  = 1'b1;
                if (k_q == pre_len_q - 8'd1) state_d = MSG;
                else                         k_d     = k_q + 8'd1;
            end
            MSG: begin
                raddr    = j_q;
                write_en = 1'b1;
                waddr    = BASE8 + pre_len_q + j_q;
                data_in  = data_out ^ {2'b00, LFSR};
                LFSR_en  = 1'b1;
                if (j_q == LAST_MSG) state_d = DONE;
                else                 j_d     = j_q + 8'd1;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // init masks every strobe in the same cycle so a mid-run reset never lands a write
        if (init) begin
            write_en  = 1'b0;
            LFSR_en   = 1'b0;
            load_LFSR = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q   <= IDLE;
            pre_len_q <= 8'd0;
            taps_q    <= 6'd0;
            start_q   <= 6'd0;
            k_q       <= 8'd0;
            j_q       <= 8'd0;
        end else begin
            state_q   <= state_d;
            pre_len_q <= pre_len_d;
            taps_q    <= taps_d;
            start_q   <= start_d;
            k_q       <= k_d;
            j_q       <= j_d;
        end
    end

endmodule

// File: tb/tb_lfsr_enc_seq.sv
// tb/tb_lfsr_enc_seq.sv - table-driven bench with dat_mem and lfsr6 models around lfsr_enc_seq
module tb_lfsr_enc_seq;

    localparam int MSG_LEN = 50;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       go = 1'b0;
    logic [7:0] raddr, waddr, data_in, data_out;
    logic       write_en, LFSR_en, load_LFSR, busy, done;
    logic [5:0] taps, start, lfsr;

    logic [7:0] mem [0:255];
    logic [7:0] exp_mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_enc_seq dut (
        .clk(clk), .init(init), .go(go),
        .raddr(raddr), .waddr(waddr), .write_en(write_en), .data_in(data_in),
        .data_out(data_out), .LFSR_en(LFSR_en), .load_LFSR(load_LFSR),
        .taps(taps), .start(start), .LFSR(lfsr), .busy(busy), .done(done)
    );

    assign data_out = mem[raddr];

    function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    always @(posedge clk) begin
        if (write_en) mem[waddr] <= data_in;
        if (load_LFSR)    lfsr <= start;
        else if (LFSR_en) lfsr <= lfsr_next(lfsr, taps);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] pre;
        logic [5:0] tp;
        logic [5:0] st;
        logic [7:0] seed;
        int         exp_done;
        logic [7:0] exp_first_waddr;
        logic [7:0] exp_first_byte;
        logic [7:0] exp_last_waddr;
    } vec_t;

    // Prog4 reference: preamble pads then message bytes, each XORed with successive LFSR states
    task automatic load_mem(input vec_t v);
        int p;
        logic [5:0] s;
        for (int a = 0; a < 256; a++) mem[a] = 8'hEE;
        for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'(v.seed + 8'(i * 7));
        mem[61] = v.pre;
        mem[62] = {2'b10, v.tp};
        mem[63] = {2'b01, v.st};
        for (int a = 0; a < 256; a++) exp_mem[a] = mem[a];
        p = (v.pre > 8'd14) ? 14 : int'(v.pre);
        s = v.st;
        for (int i = 0; i < p + MSG_LEN; i++) begin
            exp_mem[64 + i] = (i < p) ? (8'h5F ^ {2'b00, s}) : (mem[i - p] ^ {2'b00, s});
            s = lfsr_next(s, v.tp);
        end
    endtask

    task automatic run(input vec_t v, input int go_delay, input int init_at, input string tag);
        int cycle, done_cycle, nw, bad_img, idle_bad, post_bad, iat;
        logic [7:0] first_wa, first_b, last_wa;
        logic got_done;
        load_mem(v);
        @(negedge clk);
        init = 1'b1;
        go   = (go_delay == 0);
        @(negedge clk);
        check({tag, "_reset_outs"}, {31'd0, write_en | busy | done | LFSR_en | load_LFSR}, 32'd0);
        init = 1'b0;
        cycle = 0; nw = 0; got_done = 1'b0; done_cycle = -1; idle_bad = 0; iat = init_at;
        first_wa = 8'h00; first_b = 8'h00; last_wa = 8'h00;
        while (!got_done && cycle < 400) begin
            if (cycle == go_delay) go = 1'b1;
            if (cycle < go_delay && (busy || write_en)) idle_bad++;
            if (cycle == iat) begin
                init = 1'b1;
                #1;
                check({tag, "_init_masks_write"}, {30'd0, write_en, busy}, 32'd0);
                @(negedge clk);
                init = 1'b0;
                #1;
                check({tag, "_idle_after_init"}, {30'd0, busy, write_en}, 32'd0);
                cycle = 0; nw = 0; iat = -1;
            end
            if (write_en) begin
                if (nw == 0) begin first_wa = waddr; first_b = data_in; end
                last_wa = waddr;
                nw++;
            end
            if (done) begin
                got_done = 1'b1;
                done_cycle = cycle;
            end else begin
                @(negedge clk);
                cycle++;
            end
        end
        check({tag, "_done_cycle"}, done_cycle, v.exp_done);
        check({tag, "_first_waddr"}, {24'd0, first_wa}, {24'd0, v.exp_first_waddr});
        check({tag, "_first_byte"}, {24'd0, first_b}, {24'd0, v.exp_first_byte});
        check({tag, "_last_waddr"}, {24'd0, last_wa}, {24'd0, v.exp_last_waddr});
        if (go_delay > 0) check({tag, "_idle_while_go_low"}, idle_bad, 0);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        post_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!done || write_en || busy) post_bad++;
        end
        check({tag, "_done_sticky"}, post_bad, 0);
        bad_img = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad_img++;
        check({tag, "_image_mismatch_bytes"}, bad_img, 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'd7,   6'h21, 6'h01, 8'h00, 62, 8'd64, 8'h5E, 8'd120};
        vecs[1] = '{8'd0,   6'h21, 6'h01, 8'h10, 55, 8'd64, 8'h11, 8'd113};
        vecs[2] = '{8'd200, 6'h2D, 6'h2A, 8'h55, 69, 8'd64, 8'h75, 8'd127};
        vecs[3] = '{8'd0,   6'h00, 6'h3F, 8'hC3, 55, 8'd64, 8'hFC, 8'd113};
        vecs[4] = '{8'd14,  6'h30, 6'h15, 8'h9A, 69, 8'd64, 8'h4A, 8'd127};
        vecs[5] = '{8'd15,  6'h03, 6'h3F, 8'h01, 69, 8'd64, 8'h60, 8'd127};

        for (int i = 0; i < 6; i++) run(vecs[i], 0, -1, $sformatf("vec%0d", i));

        run('{8'd7, 6'h21, 6'h01, 8'h00, 72, 8'd64, 8'h5E, 8'd120}, 10, -1, "go_late");
        run('{8'd7, 6'h21, 6'h01, 8'h00, 62, 8'd64, 8'h5E, 8'd120}, 0, 8, "init_mid_pre");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
